// File: rtl/nibble_serial_sub_if.sv
// nibble_serial_sub_if: request/result bundle for nibble_serial_sub.
// Optional macro: SUB_OVF_EN adds the signed-overflow flag ovf.
//
// Handshake: start is accepted on a rising clk edge only while busy is low
// (IDLE or DONE). Operands a, b and bin are captured on that edge. A start
// seen while busy is high is dropped, not queued. Each accepted start yields
// exactly one done, a single-cycle strobe on which d/bout (and ovf) are
// valid. Those outputs then hold until the next completion or reset.
interface nibble_serial_sub_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;
`ifdef SUB_OVF_EN
   logic             ovf;
`endif
   logic [1:0]       dbg_state;

`ifdef SUB_OVF_EN
   modport master (output start, a, b, bin,
                   input  busy, done, d, bout, ovf, dbg_state);
   modport slave  (input  start, a, b, bin,
                   output busy, done, d, bout, ovf, dbg_state);
`else
   modport master (output start, a, b, bin,
                   input  busy, done, d, bout, dbg_state);
   modport slave  (input  start, a, b, bin,
                   output busy, done, d, bout, dbg_state);
`endif
endinterface

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: WIDTH-bit a - b - bin computed four bits per clock.
// Each cycle one borrow-lookahead nibble stage runs and its borrow-out is
// registered for the next nibble, so the per-cycle path is independent of
// WIDTH. Latency is WIDTH/4 cycles from start acceptance to done.
// Optional macro: SUB_OVF_EN enables the registered signed-overflow output.
module nibble_serial_sub #(
   parameter int WIDTH = 16
) (
   input logic               clk,
   input logic               rst,
   nibble_serial_sub_if.slave bus
);
   localparam int N  = WIDTH / 4;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_r, b_r;      // operands, shifted right one nibble per cycle
   logic [WIDTH-1:0] acc;           // difference nibbles, filled from the top
   logic             c_r;           // borrow into the current nibble
   logic [KW-1:0]    k;             // nibble index
   logic [WIDTH-1:0] d_r;
   logic             bout_r;
`ifdef SUB_OVF_EN
   logic             a_msb, b_msb;
   logic             ovf_r;
`endif

   logic             accept;
   logic             last;
   logic [3:0]       na, nb, g, p, nd;
   logic [4:0]       c;
   logic [WIDTH+3:0] acc_cat;
   logic [WIDTH-1:0] acc_next;

   assign accept = (state != RUN) && bus.start;
   assign last   = (k == KW'(N - 1));

   // State register; reset aborts any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: IDLE and DONE both accept start; RUN lasts N cycles.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = bus.start ? RUN : IDLE;
         RUN:        state_nxt = last ? DONE : RUN;
         default:    state_nxt = IDLE;
      endcase
   end

   // One 4-bit borrow-lookahead stage on the low nibble of the operands.
   always_comb begin
      na   = a_r[3:0];
      nb   = b_r[3:0];
      g    = ~na & nb;
      p    = ~(na ^ nb);
      c[0] = c_r;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
      nd       = na ^ nb ^ c[3:0];
      acc_cat  = {nd, acc};
      acc_next = acc_cat[WIDTH+3:4];
   end

   // Operand capture, per-nibble progress, and result registers that only
   // change on the final RUN cycle so d is never seen half-built.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         c_r    <= 1'b0;
         k      <= '0;
         d_r    <= '0;
         bout_r <= 1'b0;
`ifdef SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf_r  <= 1'b0;
`endif
      end else if (accept) begin
         a_r   <= bus.a;
         b_r   <= bus.b;
         acc   <= '0;
         c_r   <= bus.bin;
         k     <= '0;
`ifdef SUB_OVF_EN
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1];
`endif
      end else if (state == RUN) begin
         a_r <= a_r >> 4;
         b_r <= b_r >> 4;
         acc <= acc_next;
         c_r <= c[4];
         k   <= k + KW'(1);
         if (last) begin
            d_r    <= acc_next;
            bout_r <= c[4];
`ifdef SUB_OVF_EN
            ovf_r  <= (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
`endif
         end
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.d         = d_r;
   assign bus.bout      = bout_r;
   assign bus.dbg_state = state;
`ifdef SUB_OVF_EN
   assign bus.ovf       = ovf_r;
`endif
endmodule
